// File: rtl/psum_accumulator.sv
// Two-stage multiply-accumulate for one conv window: stage 1 registers the signed
// product, stage 2 folds it into a wide running sum and emits it on the window's last term.
module psum_accumulator #(
    parameter  int D_BW      = 8,
    parameter  int NUM_TERMS = 32,
    parameter  int I_SUM_BW  = 21,
    localparam int CNT_BW    = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic signed [D_BW-1:0]     i_fmap,
    input  logic signed [D_BW-1:0]     i_weight,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic signed [I_SUM_BW-1:0] o_psum,
    output logic [CNT_BW-1:0]          o_cnt
);

    localparam logic [CNT_BW-1:0] CNT_LAST = CNT_BW'(NUM_TERMS - 1);

    logic                       stall;
    logic                       in_hs;
    logic signed [2*D_BW-1:0]   fmap_ext;
    logic signed [2*D_BW-1:0]   weight_ext;
    logic signed [2*D_BW-1:0]   p_prod;
    logic                       p_valid;
    logic                       p_last;
    logic signed [I_SUM_BW-1:0] p_ext;
    logic signed [I_SUM_BW-1:0] acc;
    logic signed [I_SUM_BW-1:0] sum;

    // A held output result freezes the whole pipeline, so o_psum stays stable until taken.
    assign stall   = o_valid & ~i_ready;
    assign o_ready = ~stall;
    assign in_hs   = i_valid & o_ready;

    assign fmap_ext   = {{D_BW{i_fmap[D_BW-1]}}, i_fmap};
    assign weight_ext = {{D_BW{i_weight[D_BW-1]}}, i_weight};
    assign p_ext      = {{(I_SUM_BW - 2*D_BW){p_prod[2*D_BW-1]}}, p_prod};
    assign sum        = acc + p_ext;

    always_ff @(posedge clk) begin
        if (reset) begin
            p_prod  <= '0;
            p_valid <= 1'b0;
            p_last  <= 1'b0;
            o_cnt   <= '0;
            acc     <= '0;
            o_psum  <= '0;
            o_valid <= 1'b0;
        end else if (!stall) begin
            if (in_hs) begin
                p_prod  <= fmap_ext * weight_ext;
                p_valid <= 1'b1;
                p_last  <= (o_cnt == CNT_LAST);
                o_cnt   <= (o_cnt == CNT_LAST) ? '0 : o_cnt + CNT_BW'(1);
            end else begin
                p_valid <= 1'b0;
            end

            // A new window result overwrites a result being taken this cycle: no bubble.
            if (p_valid && p_last) begin
                o_psum  <= sum;
                o_valid <= 1'b1;
                acc     <= '0;
            end else begin
                if (p_valid) begin
                    acc <= sum;
                end
                if (o_valid && i_ready) begin
                    o_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: three instances (4, 32 and 1 terms per window) share the
// input stream; a window-sum scoreboard per instance plus directed timing checks.
module tb_psum_accumulator;

    localparam int D_BW     = 8;
    localparam int I_SUM_BW = 21;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic valid = 1'b0;
    logic signed [D_BW-1:0] fmap = '0;
    logic signed [D_BW-1:0] weight = '0;
    logic rdy[3];
    logic ordy[3];
    logic ov[3];
    logic signed [I_SUM_BW-1:0] psum[3];
    logic [1:0] cnt4;
    logic [4:0] cnt32;
    logic       cnt1;

    int checks = 0;
    int failures = 0;

    // Reference model state: pairs accepted into the current window and its running sum.
    int win_sum[3];
    int win_cnt[3];
    int n_res[3];
    logic held[3];
    logic signed [I_SUM_BW-1:0] held_psum[3];
    logic signed [I_SUM_BW-1:0] last_psum[3];
    logic signed [I_SUM_BW-1:0] exp_q0[$];
    logic signed [I_SUM_BW-1:0] exp_q1[$];
    logic signed [I_SUM_BW-1:0] exp_q2[$];
    logic signed [I_SUM_BW-1:0] got32[$];

    psum_accumulator #(.D_BW(D_BW), .NUM_TERMS(4), .I_SUM_BW(I_SUM_BW)) u4 (
        .clk(clk), .reset(reset), .i_valid(valid), .o_ready(ordy[0]), .i_fmap(fmap),
        .i_weight(weight), .o_valid(ov[0]), .i_ready(rdy[0]), .o_psum(psum[0]), .o_cnt(cnt4)
    );
    psum_accumulator #(.D_BW(D_BW), .NUM_TERMS(32), .I_SUM_BW(I_SUM_BW)) u32 (
        .clk(clk), .reset(reset), .i_valid(valid), .o_ready(ordy[1]), .i_fmap(fmap),
        .i_weight(weight), .o_valid(ov[1]), .i_ready(rdy[1]), .o_psum(psum[1]), .o_cnt(cnt32)
    );
    psum_accumulator #(.D_BW(D_BW), .NUM_TERMS(1), .I_SUM_BW(I_SUM_BW)) u1 (
        .clk(clk), .reset(reset), .i_valid(valid), .o_ready(ordy[2]), .i_fmap(fmap),
        .i_weight(weight), .o_valid(ov[2]), .i_ready(rdy[2]), .o_psum(psum[2]), .o_cnt(cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int nt(input int k);
        case (k)
            0: return 4;
            1: return 32;
            default: return 1;
        endcase
    endfunction

    function automatic int cnt_of(input int k);
        case (k)
            0: return int'(cnt4);
            1: return int'(cnt32);
            default: return int'(cnt1);
        endcase
    endfunction

    function automatic int qsz(input int k);
        case (k)
            0: return exp_q0.size();
            1: return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    task automatic q_push(input int k, input int v);
        case (k)
            0: exp_q0.push_back(I_SUM_BW'(v));
            1: exp_q1.push_back(I_SUM_BW'(v));
            default: exp_q2.push_back(I_SUM_BW'(v));
        endcase
    endtask

    task automatic q_pop(input int k, output logic signed [I_SUM_BW-1:0] v);
        case (k)
            0: v = exp_q0.pop_front();
            1: v = exp_q1.pop_front();
            default: v = exp_q2.pop_front();
        endcase
    endtask

    task automatic q_clear(input int k);
        case (k)
            0: exp_q0.delete();
            1: exp_q1.delete();
            default: exp_q2.delete();
        endcase
    endtask

    // Monitor + scoreboard, sampled on the falling edge while inputs are stable.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic signed [I_SUM_BW-1:0] e;
            if (reset) begin
                win_sum[k] = 0;
                win_cnt[k] = 0;
                held[k] = 1'b0;
                q_clear(k);
            end else begin
                chk("o_ready", ordy[k], !(ov[k] && !rdy[k]));
                chk("o_cnt", cnt_of(k), win_cnt[k]);
                if (held[k]) begin
                    chk("hold_valid", ov[k], 1);
                    chk("hold_psum", psum[k], held_psum[k]);
                end
                if (ov[k] === 1'b1 && rdy[k]) begin
                    chk("result_expected", qsz(k) > 0, 1);
                    if (qsz(k) > 0) begin
                        q_pop(k, e);
                        chk("psum", psum[k], e);
                        last_psum[k] = psum[k];
                        n_res[k]++;
                        if (k == 1) got32.push_back(psum[k]);
                    end
                end
                held[k] = ov[k] && !rdy[k];
                held_psum[k] = psum[k];
                if (valid && ordy[k]) begin
                    win_sum[k] += int'(fmap) * int'(weight);
                    win_cnt[k]++;
                    if (win_cnt[k] == nt(k)) begin
                        q_push(k, win_sum[k]);
                        win_sum[k] = 0;
                        win_cnt[k] = 0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int f, input int w);
        fmap = D_BW'(f);
        weight = D_BW'(w);
        valid = 1'b1;
        step();
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        valid = 1'b0;
        reset = 1'b1;
        step();
        step();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", ov[k], 0);
            chk("rst_psum", psum[k], 0);
            chk("rst_cnt", cnt_of(k), 0);
            chk("rst_ready", ordy[k], 1);
        end
        #1 reset = 1'b0;
        step();
    endtask

    initial begin
        int n0;
        logic found;
        for (int k = 0; k < 3; k++) begin
            rdy[k] = 1'b1;
            n_res[k] = 0;
            held[k] = 1'b0;
            win_sum[k] = 0;
            win_cnt[k] = 0;
        end
        do_reset();

        // Window of four mixed-sign pairs; result 2 cycles after the last pair, 1 cycle wide.
        send(1, 1); send(2, 3); send(-4, 5); send(7, -2);
        valid = 1'b0;
        @(negedge clk); chk("t1_valid_t1", ov[0], 0);
        @(negedge clk); chk("t1_valid_t2", ov[0], 1); chk("t1_psum", psum[0], -27);
        @(negedge clk); chk("t1_valid_t3", ov[0], 0);
        step();

        // Two back-to-back windows of (3,2).
        n0 = n_res[0];
        repeat (8) send(3, 2);
        idle(4);
        chk("t4_results", n_res[0] - n0, 2);
        chk("t4_psum", last_psum[0], 24);

        // One term per window: each pair's product on consecutive cycles.
        fmap = 8'sd5; weight = -8'sd3; valid = 1'b1; step();
        fmap = 8'sd0; weight = 8'sd9; step();
        fmap = -8'sd1; weight = -8'sd1;
        @(negedge clk); chk("t6_v0", ov[2], 1); chk("t6_p0", psum[2], -15);
        step();
        valid = 1'b0;
        @(negedge clk); chk("t6_v1", ov[2], 1); chk("t6_p1", psum[2], 0);
        step();
        @(negedge clk); chk("t6_v2", ov[2], 1); chk("t6_p2", psum[2], 1);
        step();

        // Reset mid-window discards the partial sum.
        send(1, 1);
        idle(3);
        chk("t5_cnt_start", cnt4, 0);
        send(9, 9); send(-7, 4);
        valid = 1'b0;
        @(negedge clk); chk("t5_cnt_mid", cnt4, 2);
        step();
        do_reset();
        n0 = n_res[0];
        repeat (4) send(1, 1);
        idle(4);
        chk("t5_results", n_res[0] - n0, 1);
        chk("t5_psum", last_psum[0], 4);

        // Largest-magnitude windows at 32 terms.
        do_reset();
        got32.delete();
        repeat (32) send(-128, -128);
        repeat (32) send(-128, 127);
        idle(4);
        chk("t2_count", got32.size(), 2);
        if (got32.size() == 2) begin
            chk("t2_pos", got32[0], 524288);
            chk("t2_neg", got32[1], -520192);
        end

        // Downstream stall while input keeps streaming.
        n0 = n_res[0];
        rdy[0] = 1'b0;
        fmap = 8'sd2; weight = 8'sd2; valid = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            @(negedge clk);
            if (ov[0] === 1'b1) found = 1'b1;
        end
        chk("t3_result_seen", found, 1);
        for (int i = 0; i < 3; i++) begin
            chk("t3_ready_low", ordy[0], 0);
            chk("t3_psum_held", psum[0], 16);
            chk("t3_cnt_frozen", cnt4, 1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rdy[0] = 1'b1;
        step(); step(); step();
        idle(4);
        chk("t3_results", n_res[0] - n0, 2);
        chk("t3_next_psum", last_psum[0], 16);

        // Random traffic with random back-pressure on every instance.
        for (int i = 0; i < 400; i++) begin
            valid = ($urandom_range(0, 3) != 0);
            fmap = D_BW'($urandom);
            weight = D_BW'($urandom);
            for (int k = 0; k < 3; k++) rdy[k] = ($urandom_range(0, 2) != 0);
            step();
        end
        valid = 1'b0;
        for (int k = 0; k < 3; k++) rdy[k] = 1'b1;
        for (int i = 0; i < 40 && (qsz(0) + qsz(1) + qsz(2)) != 0; i++) step();
        idle(2);
        for (int k = 0; k < 3; k++) chk("drain_empty", qsz(k), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
